ch_frame_seq: RTL and testbench
===============================

// Module: ch_frame_seq
// PURPOSE
//  Frame sequencer in front of the channel estimator/equalizer. On a frame-start pulse from
//  the timing-sync stage, forwards one long-preamble symbol (estimation phase) and then
//  NUM_SYM data symbols (equalization phase) over the Wishbone-style stream. It then drops
//  CYC_O for a guard gap so the downstream block re-arms for the next frame.
// PARAMETERS
//  SYM_LEN  256  samples per OFDM symbol (power of 2); preamble and data symbols use the same length
//  SYM_W    8    width of num_sym_i / sym_idx_o; maximum data-symbol count is 2**SYM_W-1
//  GAP_CYC  4    cycles CYC_O is held low between frames (>=1)
// PORTS
//  CLK_I       in   1      clock
//  RST_I       in   1      asynchronous, active-low reset
//  DAT_I       in   32     sample, Im[31:16] Re[15:0], Q1.15
//  WE_I,STB_I,CYC_I in 1   upstream strobes; sample valid = WE_I&STB_I&CYC_I
//  ACK_O       out  1      upstream sample accepted this cycle
//  DAT_O       out  32     registered sample to estimator/equalizer
//  CYC_O       out  1      frame envelope to downstream
//  STB_O       out  1      DAT_O valid
//  WE_O        out  1      =CYC_O
//  ACK_I       in   1      downstream accepted DAT_O
//  frame_start_i in 1      one-cycle pulse: start a frame
//  num_sym_i   in   SYM_W  data symbols in the frame; latched at the accepted frame_start_i
//  abort_i     in   1      one-cycle pulse: terminate the current frame
//  est_o       out  1      high while preamble samples are being forwarded (state PRE)
//  sym_idx_o   out  SYM_W  index of the current data symbol, 0-based
//  busy_o      out  1      state != IDLE
//  done_o      out  1      one-cycle pulse at the end of a frame's gap (normal or aborted)
//  ovr_o       out  1      sticky: frame_start_i arrived while busy; cleared only by reset
// BEHAVIOUR
//  Reset (RST_I=0, async): state=IDLE. DAT_O=0. CYC_O, STB_O, est_o, busy_o, done_o and ovr_o
//   all 0. sym_idx_o=0. All counters are 0.
//  States: IDLE -> PRE -> DATA -> DRAIN -> GAP -> IDLE.
//   PRE is followed by DRAIN directly when num_sym=0.
//  Forwarding (PRE, DATA): ACK_O = valid & (~STB_O | ACK_I). On ACK_O, DAT_O<=DAT_I and
//   STB_O<=1. Otherwise, ACK_I clears STB_O. Latency is 1 cycle; throughput is 1 sample/cycle.
//  IDLE: ACK_O=valid, so upstream samples are discarded and no data is forwarded.
//   CYC_O=0. On frame_start_i, latch num_sym_i, clear counters, set CYC_O=1, go to PRE.
//  PRE: est_o=1. samp_cnt counts accepted samples. The SYM_LEN-th accept wraps samp_cnt to 0
//   and moves to DATA, or to DRAIN when num_sym=0.
//  DATA: the SYM_LEN-th accept of each symbol increments sym_idx_o. The accept that completes
//   symbol num_sym-1 moves to DRAIN, and sym_idx_o holds at num_sym-1.
//  DRAIN: ACK_O=0. Once STB_O=0, or STB_O&ACK_I this cycle: STB_O<=0, CYC_O<=0, go to GAP.
//  GAP: CYC_O=0 and ACK_O=0 for GAP_CYC cycles. On the last gap cycle, done_o=1 and the next
//   state is IDLE.
//  abort_i: in PRE or DATA, go to GAP next cycle, with STB_O<=0 and CYC_O<=0.
//   Any pending DAT_O is dropped, and no ACK_O is issued in the abort cycle.
//   In DRAIN the effect is the same. In IDLE or GAP, abort_i is ignored.
//  frame_start_i in any state except IDLE is ignored and sets ovr_o.
//   In the IDLE cycle itself, frame_start_i wins over a simultaneous abort_i.
//  Simultaneous last-sample accept and ACK_I: the pipeline register reloads, and the state
//   still advances on the accept.
//  Total samples forwarded per normal frame = (1+num_sym)*SYM_LEN. There are no gaps inside
//   a frame other than upstream or downstream stalls.
// TESTING
//  T1 Reset: hold RST_I=0 mid-frame -> all outputs 0 asynchronously; after release, state=IDLE,
//   ovr_o=0.
//  T2 num_sym=2, continuous input, ACK_I=1 -> 768 STB_O beats; est_o high for beats 0..255;
//   sym_idx_o 0 then 1; CYC_O low 4 cycles; done_o on the 4th gap cycle.
//  T3 num_sym=0 -> exactly 256 beats with est_o=1, then DRAIN/GAP and done_o.
//  T4 Random ACK_I stalls (50%) with num_sym=3 -> DAT_O sequence equals DAT_I order;
//   no loss or duplication; 1024 beats; ACK_O never high while STB_O&~ACK_I.
//  T5 abort_i at data sample 100 of symbol 1 -> CYC_O and STB_O low the next cycle;
//   done_o after 4 cycles; the following frame_start gives a clean frame.
//  T6 frame_start_i during DATA -> ignored, ovr_o=1 and stays high; in IDLE, samples are
//   ACKed but STB_O stays 0.

Source files
------------

// File: rtl/ch_frame_seq.sv
// Frame sequencer: forwards one preamble symbol and NUM_SYM data symbols per frame over a
// Wishbone-style stream, then holds CYC_O low for a guard gap before re-arming.
module ch_frame_seq #(
  parameter int SYM_LEN = 256,
  parameter int SYM_W   = 8,
  parameter int GAP_CYC = 4
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic [31:0]      DAT_I,
  input  logic             WE_I,
  input  logic             STB_I,
  input  logic             CYC_I,
  output logic             ACK_O,
  output logic [31:0]      DAT_O,
  output logic             CYC_O,
  output logic             STB_O,
  output logic             WE_O,
  input  logic             ACK_I,
  input  logic             frame_start_i,
  input  logic [SYM_W-1:0] num_sym_i,
  input  logic             abort_i,
  output logic             est_o,
  output logic [SYM_W-1:0] sym_idx_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             ovr_o
);
  localparam int CNT_W = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [CNT_W-1:0] SAMP_LAST = CNT_W'(SYM_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_DATA, S_DRAIN, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] samp_cnt_q;
  logic [SYM_W-1:0] num_sym_q;
  logic [GAP_W-1:0] gap_cnt_q;

  logic valid, fwd, accept, sym_end, last_sym, drain_done, gap_end;

  assign valid      = WE_I & STB_I & CYC_I;
  assign fwd        = (state_q == S_PRE) || (state_q == S_DATA);
  // An abort cycle never accepts, so the sample it would have taken stays upstream.
  assign accept     = fwd & valid & (~STB_O | ACK_I) & ~abort_i;
  assign sym_end    = accept && (samp_cnt_q == SAMP_LAST);
  assign last_sym   = (sym_idx_o == num_sym_q - SYM_W'(1));
  assign drain_done = ~STB_O | ACK_I;
  assign gap_end    = (state_q == S_GAP) && (gap_cnt_q == GAP_LAST);

  // IDLE swallows upstream samples so the source never stalls between frames.
  assign ACK_O  = (state_q == S_IDLE) ? valid : accept;
  assign WE_O   = CYC_O;
  assign est_o  = (state_q == S_PRE);
  assign busy_o = (state_q != S_IDLE);
  assign done_o = gap_end;

  always_comb begin
    // NOTE: default assigned first so every path drives state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (frame_start_i) state_d = S_PRE;
      S_PRE: begin
        if (abort_i)      state_d = S_GAP;
        else if (sym_end) state_d = (num_sym_q == '0) ? S_DRAIN : S_DATA;
      end
      S_DATA: begin
        if (abort_i)                  state_d = S_GAP;
        else if (sym_end && last_sym) state_d = S_DRAIN;
      end
      S_DRAIN: if (abort_i || drain_done) state_d = S_GAP;
      S_GAP:   if (gap_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q    <= S_IDLE;
      DAT_O      <= '0;
      STB_O      <= 1'b0;
      CYC_O      <= 1'b0;
      samp_cnt_q <= '0;
      sym_idx_o  <= '0;
      num_sym_q  <= '0;
      gap_cnt_q  <= '0;
      ovr_o      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (frame_start_i && (state_q != S_IDLE)) ovr_o <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (frame_start_i) begin
            num_sym_q  <= num_sym_i;
            samp_cnt_q <= '0;
            sym_idx_o  <= '0;
            gap_cnt_q  <= '0;
            CYC_O      <= 1'b1;
          end
        end
        S_PRE, S_DATA: begin
          if (abort_i) begin
            STB_O <= 1'b0;
            CYC_O <= 1'b0;
          end else if (accept) begin
            DAT_O      <= DAT_I;
            STB_O      <= 1'b1;
            samp_cnt_q <= samp_cnt_q + CNT_W'(1);
            if (sym_end && (state_q == S_DATA) && !last_sym)
              sym_idx_o <= sym_idx_o + SYM_W'(1);
          end else if (ACK_I) begin
            STB_O <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (abort_i || drain_done) begin
            STB_O <= 1'b0;
            CYC_O <= 1'b0;
          end
        end
        S_GAP: gap_cnt_q <= gap_end ? '0 : gap_cnt_q + GAP_W'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ch_frame_seq.sv
// Directed bench for ch_frame_seq: frame shapes, stalls, abort, overrun and reset behaviour.
module tb_ch_frame_seq;
  localparam int SYM_LEN = 256;
  localparam int SYM_W   = 8;

  logic             CLK_I, RST_I;
  logic [31:0]      DAT_I, DAT_O;
  logic             WE_I, STB_I, CYC_I, ACK_O, CYC_O, STB_O, WE_O, ACK_I;
  logic             frame_start_i, abort_i, est_o, busy_o, done_o, ovr_o;
  logic [SYM_W-1:0] num_sym_i, sym_idx_o;

  ch_frame_seq #(.SYM_LEN(SYM_LEN), .SYM_W(SYM_W), .GAP_CYC(4)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .DAT_I(DAT_I), .WE_I(WE_I), .STB_I(STB_I), .CYC_I(CYC_I),
    .ACK_O(ACK_O), .DAT_O(DAT_O), .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .ACK_I(ACK_I),
    .frame_start_i(frame_start_i), .num_sym_i(num_sym_i), .abort_i(abort_i),
    .est_o(est_o), .sym_idx_o(sym_idx_o), .busy_o(busy_o), .done_o(done_o), .ovr_o(ovr_o)
  );

  initial begin
    CLK_I = 1'b0;
    forever #5 CLK_I = ~CLK_I;
  end

  int total = 0;
  int bad   = 0;
  int acc, beats, est_acc, sym_err, order_err, stall_viol, gap_n, done_n, gap_at_done;
  int done_cyc, cyc_f;
  logic [31:0] src = 32'h1234_0000;
  logic [31:0] exp_q[$];
  bit   rnd_ack, fs_pend, ab_pend;
  logic last_ack;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs after the falling edge, sample what the next rising edge will see.
  task automatic run_cycle();
    logic [31:0]      exp_v;
    logic [SYM_W-1:0] exp_idx;
    @(negedge CLK_I);
    DAT_I         = src;
    ACK_I         = rnd_ack ? 1'($urandom_range(0, 1)) : 1'b1;
    frame_start_i = fs_pend;
    abort_i       = ab_pend;
    fs_pend       = 1'b0;
    ab_pend       = 1'b0;
    #2;
    cyc_f++;
    last_ack = ACK_O;
    if (ACK_O && STB_O && !ACK_I) stall_viol++;
    if (STB_O && ACK_I) begin
      beats++;
      if (exp_q.size() == 0) order_err++;
      else begin
        exp_v = exp_q.pop_front();
        if (DAT_O !== exp_v) order_err++;
      end
    end
    if (ACK_O && CYC_O) begin
      exp_q.push_back(DAT_I);
      if (est_o) est_acc++;
      if (acc >= SYM_LEN) begin
        exp_idx = SYM_W'((acc - SYM_LEN) / SYM_LEN);
        if (sym_idx_o !== exp_idx) sym_err++;
      end
      acc++;
    end
    if (ACK_O) src = src + 32'h0001_0003;
    if (busy_o && !CYC_O) gap_n++;
    if (done_o) begin
      done_n++;
      gap_at_done = gap_n;
      done_cyc    = cyc_f;
    end
  endtask

  task automatic start_frame(input logic [SYM_W-1:0] n, input bit rnd);
    acc = 0; beats = 0; est_acc = 0; sym_err = 0; order_err = 0; stall_viol = 0;
    gap_n = 0; done_n = 0; gap_at_done = 0; done_cyc = 0; cyc_f = 0;
    exp_q.delete();
    rnd_ack   = rnd;
    num_sym_i = n;
    fs_pend   = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_n == 0 && n < budget) begin
      run_cycle();
      n++;
    end
  endtask

  task automatic run_until_acc(input int target, input int budget);
    int n = 0;
    while (acc < target && n < budget) begin
      run_cycle();
      n++;
    end
  endtask

  initial begin
    RST_I = 1'b0; DAT_I = '0; WE_I = 1'b1; STB_I = 1'b1; CYC_I = 1'b1; ACK_I = 1'b1;
    frame_start_i = 1'b0; abort_i = 1'b0; num_sym_i = '0;
    rnd_ack = 1'b0; fs_pend = 1'b0; ab_pend = 1'b0;

    // Power-on reset
    @(negedge CLK_I); #2;
    check("rst_dat", DAT_O, 32'h0);
    check("rst_flags", {CYC_O, STB_O, WE_O, est_o, busy_o, done_o, ovr_o, sym_idx_o}, 32'h0);
    RST_I = 1'b1;

    // T2: two data symbols, no stalls
    start_frame(8'd2, 1'b0);
    wait_done(2000);
    check("t2_done", done_n, 1);
    check("t2_beats", beats, 768);
    check("t2_accepts", acc, 768);
    check("t2_est", est_acc, 256);
    check("t2_symidx", sym_err, 0);
    check("t2_order", order_err, 0);
    check("t2_left", exp_q.size(), 0);
    check("t2_gap", gap_at_done, 4);
    check("t2_cycles", done_cyc, 774);

    // T3: preamble only
    start_frame(8'd0, 1'b0);
    wait_done(1000);
    check("t3_done", done_n, 1);
    check("t3_beats", beats, 256);
    check("t3_est", est_acc, 256);
    check("t3_order", order_err, 0);
    check("t3_gap", gap_at_done, 4);
    check("t3_cycles", done_cyc, 262);

    // T4: random downstream stalls
    start_frame(8'd3, 1'b1);
    wait_done(20000);
    check("t4_done", done_n, 1);
    check("t4_beats", beats, 1024);
    check("t4_order", order_err, 0);
    check("t4_left", exp_q.size(), 0);
    check("t4_symidx", sym_err, 0);
    check("t4_stall_ack", stall_viol, 0);
    check("t4_gap", gap_at_done, 4);

    // T5: abort at sample 100 of data symbol 1
    start_frame(8'd3, 1'b0);
    run_until_acc(SYM_LEN + SYM_LEN + 100, 2000);
    check("t5_reach", acc, 612);
    ab_pend = 1'b1;
    run_cycle();
    check("t5_abort_ack", last_ack, 1'b0);
    run_cycle();
    check("t5_cyc_stb", {CYC_O, STB_O}, 2'b00);
    wait_done(50);
    check("t5_done", done_n, 1);
    check("t5_gap", gap_at_done, 4);
    check("t5_no_accept", acc, 612);
    check("t5_ovr", ovr_o, 1'b0);
    start_frame(8'd1, 1'b0);
    wait_done(2000);
    check("t5_clean_beats", beats, 512);
    check("t5_clean_order", order_err, 0);
    check("t5_clean_est", est_acc, 256);
    check("t5_clean_cycles", done_cyc, 518);

    // T6: frame start while busy is ignored and sets the sticky overrun flag
    start_frame(8'd2, 1'b0);
    run_until_acc(300, 1000);
    num_sym_i = 8'd0;
    fs_pend   = 1'b1;
    run_cycle();
    run_cycle();
    check("t6_ovr_set", ovr_o, 1'b1);
    wait_done(2000);
    check("t6_beats", beats, 768);
    check("t6_order", order_err, 0);
    check("t6_ovr_hold", ovr_o, 1'b1);
    run_cycle();
    run_cycle();
    check("t6_idle_ack", last_ack, 1'b1);
    check("t6_idle_stb", STB_O, 1'b0);
    check("t6_idle_beats", beats, 768);

    // T1: reset asserted mid-frame
    start_frame(8'd2, 1'b0);
    repeat (600) run_cycle();
    check("t1_busy_pre", busy_o, 1'b1);
    #1 RST_I = 1'b0;
    #1;
    check("t1_dat", DAT_O, 32'h0);
    check("t1_flags", {CYC_O, STB_O, WE_O, est_o, busy_o, done_o, ovr_o, sym_idx_o}, 32'h0);
    repeat (2) @(negedge CLK_I);
    RST_I = 1'b1;
    @(negedge CLK_I); #2;
    check("t1_idle", {busy_o, ovr_o, CYC_O, STB_O}, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
